// File: rtl/soc_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// soc_mem_arbiter_if
// Bundles the three buses the arbiter touches: the fetch bus (ibus), the
// load/store bus (dbus) and the single-port synchronous RAM port.
//   ibus : req, addr[31:0] -> ready, rvalid, rdata[31:0]
//   dbus : req, we, wstrb[3:0], addr[31:0], wdata[31:0]
//          -> ready, rvalid, rdata[31:0]
//   ram  : en, we[3:0], addr[RAM_AW-1:0], wdata[31:0] -> rdata[31:0]
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (core masters plus the RAM)
// ---------------------------------------------------------------------------
interface soc_mem_arbiter_if #(
    parameter int RAM_AW = 12
);
    logic              ibus_req;
    logic [31:0]       ibus_addr;
    logic              ibus_ready;
    logic              ibus_rvalid;
    logic [31:0]       ibus_rdata;

    logic              dbus_req;
    logic              dbus_we;
    logic [3:0]        dbus_wstrb;
    logic [31:0]       dbus_addr;
    logic [31:0]       dbus_wdata;
    logic              dbus_ready;
    logic              dbus_rvalid;
    logic [31:0]       dbus_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  ibus_req, ibus_addr,
        output ibus_ready, ibus_rvalid, ibus_rdata,
        input  dbus_req, dbus_we, dbus_wstrb, dbus_addr, dbus_wdata,
        output dbus_ready, dbus_rvalid, dbus_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output ibus_req, ibus_addr,
        input  ibus_ready, ibus_rvalid, ibus_rdata,
        output dbus_req, dbus_we, dbus_wstrb, dbus_addr, dbus_wdata,
        input  dbus_ready, dbus_rvalid, dbus_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/soc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// soc_mem_arbiter
// Shares one single-port synchronous RAM between the fetch bus (ibus) and
// the load/store bus (dbus). At most one access is granted per cycle; dbus
// normally wins, but ibus is forced through once it has been denied
// STARVE_LIMIT consecutive cycles. Read data (1-cycle latency) is steered
// back to the issuing master by a one-deep pending-read register.
// Ports:
//   clk   : clock, rising edge
//   rst_b : synchronous active-low reset
//   bus   : soc_mem_arbiter_if.slave (ibus, dbus and RAM port)
// ---------------------------------------------------------------------------
module soc_mem_arbiter #(
    parameter int RAM_AW       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    soc_mem_arbiter_if.slave       bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       grant_i;
    logic       grant_d;
    logic       pend_i_q, pend_i_d;
    logic       pend_d_q, pend_d_d;
    logic [3:0] starve_q, starve_d;

    // Grant is combinational in the request cycle and fully masked in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_b) begin
            if (bus.ibus_req && bus.dbus_req) begin
                if (starve_q == LIMIT) grant_i = 1'b1;
                else                   grant_d = 1'b1;
            end else if (bus.ibus_req) begin
                grant_i = 1'b1;
            end else if (bus.dbus_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign bus.ibus_ready = grant_i;
    assign bus.dbus_ready = grant_d;

    // Upper address bits are dropped, so the RAM aliases across the 4 GiB map.
    assign bus.ram_en    = grant_i | grant_d;
    assign bus.ram_addr  = grant_d ? bus.dbus_addr[RAM_AW+1:2] : bus.ibus_addr[RAM_AW+1:2];
    assign bus.ram_we    = (grant_d && bus.dbus_we) ? bus.dbus_wstrb : 4'b0000;
    assign bus.ram_wdata = bus.dbus_wdata;

    // Response data is shared and unqualified; rvalid picks the owner.
    assign bus.ibus_rvalid = pend_i_q;
    assign bus.dbus_rvalid = pend_d_q;
    assign bus.ibus_rdata  = bus.ram_rdata;
    assign bus.dbus_rdata  = bus.ram_rdata;

    always_comb begin
        pend_i_d = grant_i;
        pend_d_d = grant_d && !bus.dbus_we;
        starve_d = starve_q;
        if (!bus.ibus_req || grant_i) begin
            starve_d = 4'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pend_i_q <= 1'b0;
            pend_d_q <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            pend_i_q <= pend_i_d;
            pend_d_q <= pend_d_d;
            starve_q <= starve_d;
        end
    end

    // Address bits above the RAM window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ibus_addr[31:RAM_AW+2], bus.ibus_addr[1:0],
                                bus.dbus_addr[31:RAM_AW+2], bus.dbus_addr[1:0]};

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_soc_mem_arbiter
// Directed bench for soc_mem_arbiter with a behavioural synchronous RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 3 time units after the edge.
// ---------------------------------------------------------------------------
module tb_soc_mem_arbiter;

    localparam int RAM_AW = 12;

    logic clk;
    logic rst_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:(1<<RAM_AW)-1];

    soc_mem_arbiter_if #(.RAM_AW(RAM_AW)) bus ();

    soc_mem_arbiter #(.RAM_AW(RAM_AW), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we == 4'b0000) begin
                bus.ram_rdata <= mem[bus.ram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dwe, input logic [3:0] ds,
                         input logic [31:0] da, input logic [31:0] dd);
        bus.ibus_req   = ir;
        bus.ibus_addr  = ia;
        bus.dbus_req   = dr;
        bus.dbus_we    = dwe;
        bus.dbus_wstrb = ds;
        bus.dbus_addr  = da;
        bus.dbus_wdata = dd;
    endtask

    logic prev_i, prev_d;
    logic exp_i;
    logic [31:0] prev_word;
    int grants;

    initial begin
        for (int i = 0; i < (1<<RAM_AW); i++) mem[i] = 32'hA500_0000 | i;
        mem[8] = 32'h1122_3344;

        // ---------------- reset with both requests high ----------------
        rst_b = 1'b0;
        drive(1'b1, 32'h0000_0040, 1'b1, 1'b0, 4'b0000, 32'h0000_0080, 32'h0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("rst_ibus_ready", {31'b0, bus.ibus_ready}, 32'd0);
            chk("rst_dbus_ready", {31'b0, bus.dbus_ready}, 32'd0);
            chk("rst_ram_en",     {31'b0, bus.ram_en},     32'd0);
            chk("rst_ram_we",     {28'b0, bus.ram_we},     32'd0);
            chk("rst_rvalids",    {30'b0, bus.ibus_rvalid, bus.dbus_rvalid}, 32'd0);
            next_cycle();
        end
        rst_b = 1'b1;
        settle();
        chk("rel_dbus_ready", {31'b0, bus.dbus_ready}, 32'd1);
        chk("rel_ibus_ready", {31'b0, bus.ibus_ready}, 32'd0);
        chk("rel_rvalids",    {30'b0, bus.ibus_rvalid, bus.dbus_rvalid}, 32'd0);
        next_cycle();

        // ---------------- single fetch ----------------
        drive(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        settle();
        chk("fetch_ready",  {31'b0, bus.ibus_ready}, 32'd1);
        chk("fetch_dready", {31'b0, bus.dbus_ready}, 32'd0);
        chk("fetch_addr",   {20'b0, bus.ram_addr},   32'd4);
        chk("fetch_en",     {31'b0, bus.ram_en},     32'd1);
        chk("rel_load_rvalid", {31'b0, bus.dbus_rvalid}, 32'd1);
        chk("rel_load_rdata",  bus.dbus_rdata, 32'hA500_0020);
        next_cycle();
        drive(1'b1, 32'h0001_0010, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        settle();
        chk("alias_addr",    {20'b0, bus.ram_addr},   32'd4);
        chk("fetch_rvalid",  {31'b0, bus.ibus_rvalid}, 32'd1);
        chk("fetch_drvalid", {31'b0, bus.dbus_rvalid}, 32'd0);
        chk("fetch_rdata",   bus.ibus_rdata, 32'hA500_0004);
        next_cycle();

        // ---------------- store then load ----------------
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF);
        settle();
        chk("st_ready", {31'b0, bus.dbus_ready}, 32'd1);
        chk("st_we",    {28'b0, bus.ram_we},     32'h3);
        chk("st_addr",  {20'b0, bus.ram_addr},   32'd8);
        chk("st_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0000_0020, 32'h0);
        settle();
        chk("ld_ready",   {31'b0, bus.dbus_ready}, 32'd1);
        chk("ld_we",      {28'b0, bus.ram_we},     32'h0);
        chk("st_norvalid", {30'b0, bus.ibus_rvalid, bus.dbus_rvalid}, 32'd0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        settle();
        chk("ld_rvalid", {31'b0, bus.dbus_rvalid}, 32'd1);
        chk("ld_rdata",  bus.dbus_rdata, 32'h1122_BEEF);
        next_cycle();

        // ---------------- starvation: both requests held ----------------
        prev_i = 1'b0;
        prev_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0000_0040, 1'b1, 1'b0, 4'b0000, 32'h0000_0080, 32'h0);
            settle();
            exp_i = ((i % 5) == 4);
            chk($sformatf("stv_iready_%0d", i), {31'b0, bus.ibus_ready}, {31'b0, exp_i});
            chk($sformatf("stv_dready_%0d", i), {31'b0, bus.dbus_ready}, {31'b0, !exp_i});
            chk($sformatf("stv_rv_%0d", i), {30'b0, bus.ibus_rvalid, bus.dbus_rvalid},
                {30'b0, prev_i, prev_d});
            prev_i = exp_i;
            prev_d = !exp_i;
            next_cycle();
        end

        // ---------------- throughput: alternating masters ----------------
        grants    = 0;
        prev_word = 32'h0;
        for (int k = 0; k < 101; k++) begin
            if (k < 100) begin
                if ((k % 2) == 0)
                    drive(1'b1, (200 + k) * 4, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
                else
                    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, (200 + k) * 4, 32'h0);
            end else begin
                drive(1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
            end
            settle();
            if (bus.ibus_ready || bus.dbus_ready) grants++;
            if (k > 0) begin
                // response of the request issued in cycle k-1
                chk($sformatf("tp_rv_%0d", k), {30'b0, bus.ibus_rvalid, bus.dbus_rvalid},
                    (((k - 1) % 2) == 0) ? 32'd2 : 32'd1);
                chk($sformatf("tp_rdata_%0d", k), bus.ibus_rdata, 32'hA500_0000 | (200 + k - 1));
            end
            next_cycle();
        end
        chk("tp_grants", grants, 32'd100);

        // ---------------- reset mid-read ----------------
        drive(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        settle();
        chk("mr_grant", {31'b0, bus.ibus_ready}, 32'd1);
        next_cycle();
        rst_b = 1'b0;
        settle();
        chk("mr_ready_in_rst", {31'b0, bus.ibus_ready}, 32'd0);
        chk("mr_prev_rvalid",  {31'b0, bus.ibus_rvalid}, 32'd1);
        next_cycle();
        rst_b = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        settle();
        chk("mr_rvalid_after", {31'b0, bus.ibus_rvalid}, 32'd0);
        chk("mr_starve_cnt",   {28'b0, dut.starve_q},    32'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
